// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Occupancy encodings double as the skid controller's state values.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Execute-stage NOP encoding; used to build the bubble payload.
    localparam logic [7:0] NOP_ALUOP = 8'h11;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// EMPTY/ONE/FULL controller for the two-entry skid buffer.
// The state register is the occupancy count, so it is exported directly.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       load_main,
    output logic       load_skid,
    output logic       main_from_skid,
    output logic [1:0] occupancy
);

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;
    logic       consume;

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready_q & ~flush;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d   = OCC_ONE;
                        load_main = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = OCC_FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        state_d        = OCC_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        // Ready is computed from next state so it can come straight off a flop.
        in_ready_d = (state_d != OCC_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register carrying an opaque payload with valid/ready,
// optional skid buffer (registered in_ready) and a flush that injects BUBBLE.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned    DW     = 32,
    parameter logic [DW-1:0]  BUBBLE = '0,
    parameter bit             SKID   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy
);

    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    if (SKID) begin : g_skid
        pipe_skid_ctrl u_ctrl (
            .clk            (clk),
            .rst            (rst),
            .flush          (flush),
            .in_valid       (in_valid),
            .out_ready      (out_ready),
            .in_ready       (in_ready),
            .out_valid      (out_valid),
            .load_main      (load_main),
            .load_skid      (load_skid),
            .main_from_skid (main_from_skid),
            .occupancy      (occupancy)
        );
    end else begin : g_single
        logic main_v_q;
        logic accept;

        assign in_ready       = ~main_v_q | out_ready;
        assign accept         = in_valid & in_ready & ~flush;
        assign load_main      = accept;
        assign load_skid      = 1'b0;
        assign main_from_skid = 1'b0;
        assign out_valid      = main_v_q;
        assign occupancy      = {1'b0, main_v_q};

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                main_v_q <= 1'b0;
            end else if (accept) begin
                main_v_q <= 1'b1;
            end else if (out_ready) begin
                main_v_q <= 1'b0;
            end
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = BUBBLE;
            skid_d = BUBBLE;
        end else begin
            if (load_main) begin
                main_d = in_data;
            end else if (main_from_skid) begin
                main_d = skid_q;
            end
            if (load_skid) begin
                skid_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_data = out_valid ? main_q : BUBBLE;

endmodule
